// File: rtl/alu_multicycle.sv
// Datapath ALU for the MIPS EX stage: single-cycle logic/add/sub/slt plus
// iterative shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Sel,
    output logic [WIDTH-1:0] Res,
    output logic [WIDTH-1:0] Hi,
    output logic             zero_flag,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [3:0] SEL_ADD = 4'b0001;
    localparam logic [3:0] SEL_SUB = 4'b0010;
    localparam logic [3:0] SEL_MUL = 4'b0011;
    localparam logic [3:0] SEL_DIV = 4'b0100;
    localparam logic [3:0] SEL_AND = 4'b0101;
    localparam logic [3:0] SEL_OR  = 4'b0110;
    localparam logic [3:0] SEL_NOR = 4'b0111;
    localparam logic [3:0] SEL_SLT = 4'b1000;
    localparam logic [3:0] SEL_XOR = 4'b1001;

    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t state_r, state_nxt_s;

    logic [WIDTH-1:0]   a_r, b_r, res_r, hi_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH:0]     rem_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               is_div_r, zf_r, dbz_r, busy_r, done_r;

    logic [WIDTH-1:0]   a_nxt_s, b_nxt_s, res_nxt_s, hi_nxt_s;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic [WIDTH:0]     rem_nxt_s;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               is_div_nxt_s, zf_nxt_s, dbz_nxt_s, busy_nxt_s, done_nxt_s;

    logic [WIDTH-1:0]   alu_s;
    logic               div_zero_s, long_op_s, last_iter_s;

    logic [WIDTH-1:0]   mul_addend_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_acc_s;

    logic [WIDTH+1:0]   div_shift_s, div_diff_s;
    logic               div_ge_s;
    logic [WIDTH:0]     rem_step_s;
    logic [WIDTH-1:0]   quo_step_s;

    assign div_zero_s  = (Sel == SEL_DIV) && (B == ZERO_W);
    assign long_op_s   = (Sel == SEL_MUL) || ((Sel == SEL_DIV) && !div_zero_s);
    assign last_iter_s = (cnt_r == CNT_ONE);

    // Shift-add multiply: product high half accumulates, multiplier shifts out LSB first.
    assign mul_addend_s = acc_r[0] ? a_r : ZERO_W;
    assign mul_sum_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend_s};
    assign mul_acc_s    = {mul_sum_s, acc_r[WIDTH-1:1]};

    // Restoring divide: the borrow out of the trial subtraction decides the quotient bit.
    assign div_shift_s = {rem_r, acc_r[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {2'b00, b_r};
    assign div_ge_s    = ~div_diff_s[WIDTH+1];
    assign rem_step_s  = div_ge_s ? div_diff_s[WIDTH:0] : div_shift_s[WIDTH:0];
    assign quo_step_s  = {acc_r[WIDTH-2:0], div_ge_s};

    // Single-cycle operation result.
    always_comb begin
        alu_s = ZERO_W;
        case (Sel)
            SEL_ADD: alu_s = A + B;
            SEL_SUB: alu_s = A - B;
            SEL_AND: alu_s = A & B;
            SEL_OR:  alu_s = A | B;
            SEL_NOR: alu_s = ~(A | B);
            SEL_SLT: alu_s = (A < B) ? ONE_W : ZERO_W;
            SEL_XOR: alu_s = A ^ B;
            default: alu_s = ZERO_W;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && long_op_s) state_nxt_s = RUN;
                else                    state_nxt_s = IDLE;
            end
            RUN: begin
                if (last_iter_s) state_nxt_s = IDLE;
                else             state_nxt_s = RUN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output/datapath next values; everything holds unless a step or completion applies.
    always_comb begin
        a_nxt_s      = a_r;
        b_nxt_s      = b_r;
        acc_nxt_s    = acc_r;
        rem_nxt_s    = rem_r;
        cnt_nxt_s    = cnt_r;
        is_div_nxt_s = is_div_r;
        res_nxt_s    = res_r;
        hi_nxt_s     = hi_r;
        zf_nxt_s     = zf_r;
        dbz_nxt_s    = dbz_r;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && long_op_s) begin
                    a_nxt_s      = A;
                    b_nxt_s      = B;
                    rem_nxt_s    = {(WIDTH+1){1'b0}};
                    is_div_nxt_s = (Sel == SEL_DIV);
                    acc_nxt_s    = (Sel == SEL_DIV) ? {ZERO_W, A} : {ZERO_W, B};
                    cnt_nxt_s    = CNT_INIT;
                    busy_nxt_s   = 1'b1;
                end else if (start && div_zero_s) begin
                    res_nxt_s  = ONES_W;
                    hi_nxt_s   = A;
                    zf_nxt_s   = 1'b0;
                    dbz_nxt_s  = 1'b1;
                    done_nxt_s = 1'b1;
                end else if (start) begin
                    res_nxt_s  = alu_s;
                    hi_nxt_s   = ZERO_W;
                    zf_nxt_s   = (alu_s == ZERO_W);
                    dbz_nxt_s  = 1'b0;
                    done_nxt_s = 1'b1;
                end else begin
                    done_nxt_s = 1'b0;
                end
            end
            RUN: begin
                cnt_nxt_s = cnt_r - CNT_ONE;
                if (is_div_r) begin
                    acc_nxt_s = {acc_r[2*WIDTH-1:WIDTH], quo_step_s};
                    rem_nxt_s = rem_step_s;
                end else begin
                    acc_nxt_s = mul_acc_s;
                end
                if (last_iter_s) begin
                    res_nxt_s  = is_div_r ? quo_step_s : mul_acc_s[WIDTH-1:0];
                    hi_nxt_s   = is_div_r ? rem_step_s[WIDTH-1:0] : mul_acc_s[2*WIDTH-1:WIDTH];
                    zf_nxt_s   = (res_nxt_s == ZERO_W);
                    dbz_nxt_s  = 1'b0;
                    busy_nxt_s = 1'b0;
                    done_nxt_s = 1'b1;
                end else begin
                    busy_nxt_s = 1'b1;
                end
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= ZERO_W;
            b_r      <= ZERO_W;
            acc_r    <= {(2*WIDTH){1'b0}};
            rem_r    <= {(WIDTH+1){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= 1'b0;
            res_r    <= ZERO_W;
            hi_r     <= ZERO_W;
            zf_r     <= 1'b0;
            dbz_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            a_r      <= a_nxt_s;
            b_r      <= b_nxt_s;
            acc_r    <= acc_nxt_s;
            rem_r    <= rem_nxt_s;
            cnt_r    <= cnt_nxt_s;
            is_div_r <= is_div_nxt_s;
            res_r    <= res_nxt_s;
            hi_r     <= hi_nxt_s;
            zf_r     <= zf_nxt_s;
            dbz_r    <= dbz_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    assign Res         = res_r;
    assign Hi          = hi_r;
    assign zero_flag   = zf_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised next-generation datapath ALU for the MIPS core, with the same 4-bit operation encoding as the current single-cycle ALU.
- Logic ops, add/sub and set-less-than complete in one clock.
- Multiply and divide run as iterative multi-cycle units, with a start/busy/done handshake and a Hi result register (upper product or remainder).
- Sits in EX; the control FSM stalls on busy.

Parameters:
- WIDTH, 32, operand and result width in bits (WIDTH >= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request: sample A, B and Sel on this edge.
- A  input  WIDTH  operand A (unsigned).
- B  input  WIDTH  operand B (unsigned).
- Sel  input  4  operation select.
- Res  output  WIDTH  registered primary result (low product or quotient for mul/div).
- Hi  output  WIDTH  registered secondary result (high product or remainder).
- zero_flag  output  1  registered; 1 when the last written Res == 0.
- busy  output  1  high while a mul/div iteration is in progress.
- done  output  1  one-cycle pulse when Res/Hi/zero_flag/div_by_zero update.
- div_by_zero  output  1  registered; 1 when the last completed op was a divide with B == 0.

Behaviour:
- Reset (rst_n low, asynchronous): Res=0, Hi=0, zero_flag=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0, internal operand registers=0.
- Sel encoding:
  - 0000: zero
  - 0001: A+B
  - 0010: A-B
  - 0011: A*B
  - 0100: A/B
  - 0101: A&B
  - 0110: A|B
  - 0111: ~(A|B)
  - 1000: unsigned A<B ? 1 : 0
  - 1001: A^B
  - others: zero
- Width rules: add/sub wrap modulo 2^WIDTH, no carry/overflow output. Single-cycle ops write Hi=0.
- States: IDLE, RUN.
- IDLE, start=1 with a single-cycle op, or Sel=0100 with B==0, on edge N:
  - Res, Hi, zero_flag and div_by_zero are written at edge N.
  - done=1 for the cycle after edge N; busy stays 0; state stays IDLE.
  - Latency is 1.
- Divide-by-zero result: Res = all ones, Hi = A, div_by_zero = 1.
- IDLE, start=1 with Sel=0011, or Sel=0100 with B!=0, on edge N:
  - A, B and the op are latched; busy=1 after edge N; state=RUN; counter=WIDTH.
- RUN, one iteration per edge:
  - Multiply: shift-add, LSB first, on a 2*WIDTH-bit accumulator.
  - Divide: restoring, MSB first; the remainder register is WIDTH+1 bits.
  - Counter decrements each iteration. The iteration at edge N+WIDTH is the last.
  - At edge N+WIDTH: Res/Hi written, zero_flag from the new Res, div_by_zero=0, busy=0, done=1 for one cycle, state=IDLE.
  - Multiply output: Res = product[WIDTH-1:0], Hi = product[2W-1:W].
  - Divide output: Res = quotient, Hi = remainder.
- start while busy=1: ignored completely. Latched operands are unaffected and no extra done is produced.
- start in the cycle done=1 (IDLE): accepted normally, so back-to-back ops are allowed.
- done is never high for 2 consecutive cycles from a single op; back-to-back single-cycle ops may keep done high continuously.
- Res, Hi, zero_flag and div_by_zero hold their values until the next completion. Inputs may change freely after the start edge.
- Reset mid-RUN: abort immediately to reset values; no done is produced.

Test Plan (WIDTH=32):
- Sel=0001, A=5, B=7, start 1 cycle -> next cycle Res=12, Hi=0, zero_flag=0, done=1 for 1 cycle, busy never 1.
- Sel=0010, A=3, B=3 -> Res=0, zero_flag=1. Then Sel=1000, A=2, B=9 -> Res=1, zero_flag=0, done high for both cycles.
- Sel=0011, A=0xFFFFFFFF, B=2 -> busy high 32 cycles, done at edge N+32, Res=0xFFFFFFFE, Hi=0x00000001, zero_flag=0.
- Sel=0100, A=100, B=7 -> after 32 cycles Res=14, Hi=2, div_by_zero=0. Then Sel=0100, A=0x1234, B=0 -> 1-cycle done, Res=0xFFFFFFFF, Hi=0x1234, div_by_zero=1.
- Start a multiply of 6*7, pulse start with Sel=0001 while busy -> request ignored, single done, Res=42, Hi=0.
- Start a divide of 1000/3, drop rst_n at iteration 10 -> all outputs 0 immediately, no done. After release, Sel=0101, A=0xF0, B=0x3C -> Res=0x30.
